pipe_stage_reg: RTL and testbench

- Generic, parametrised inter-stage pipeline register for the 5-stage MIPS core.
- Replaces the per-stage hand-written registers (F/D, D/E, E/M, M/W).
- Carries PC, an opaque payload bus, a valid flag and a branch-delay flag.
- Supports stall (hold), flush (bubble keeping PC), exception request (bubble with PC forced to the handler vector), a hold-state FSM, and saturating per-stage stall/bubble performance counters.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/sat_counter.sv | 25 ++
 rtl/pipe_stage_reg.sv | 120 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage MIPS core pipeline registers.
//   EXC_VEC_DEFAULT / RESET_PC_DEFAULT : default PC values for pipe_stage_reg
//   ST_RUN / ST_HELD                   : hold-state encoding
//   FD_W / DE_W / EM_W / MW_W          : payload widths of the four stage registers
package cpu_pkg;

  localparam logic [31:0] EXC_VEC_DEFAULT  = 32'h00004180;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h00000000;

  localparam logic ST_RUN  = 1'b0;
  localparam logic ST_HELD = 1'b1;

  typedef enum logic {
    S_RUN  = ST_RUN,
    S_HELD = ST_HELD
  } hold_state_e;

  // F/D: instr + pc+4
  localparam int FD_W = 64;
  // D/E: instr, rs/rt values, sign-extended imm, decoded controls
  localparam int DE_W = 160;
  // E/M: ALU result, store data, HI/LO, controls
  localparam int EM_W = 160;
  // M/W: load data, ALU result, write-back controls
  localparam int MW_W = 96;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the per-stage performance counters.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, zeroes the count
//   clr   : synchronous clear, wins over inc
//   inc   : add one unless already at all-ones
//   cnt   : current count
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register (F/D, D/E, E/M, M/W).
//
//   state  | meaning
//   -------+-----------------------------------------------
//   S_RUN  | register follows upstream (load/flush/req)
//   S_HELD | register is stalled and holding its contents
//
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   req                      : exception request, bubble with PC = EXC_VEC
//   flush                    : bubble, PC still taken from in_pc
//   stall                    : hold current contents
//   in_pc/in_payload/
//   in_valid/in_bd           : upstream slot
//   cnt_clr                  : clear both performance counters
//   out_pc/out_payload/
//   out_valid/out_bd         : registered slot
//   out_new                  : first cycle a valid instruction is presented
//   out_held                 : FSM is in S_HELD
//   stall_cnt/bubble_cnt     : saturating performance counters
module pipe_stage_reg
  import cpu_pkg::*;
#(
  parameter int          DATA_W   = 160,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] EXC_VEC  = EXC_VEC_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              flush,
  input  logic              stall,
  input  logic [31:0]       in_pc,
  input  logic [DATA_W-1:0] in_payload,
  input  logic              in_valid,
  input  logic              in_bd,
  input  logic              cnt_clr,
  output logic [31:0]       out_pc,
  output logic [DATA_W-1:0] out_payload,
  output logic              out_valid,
  output logic              out_bd,
  output logic              out_new,
  output logic              out_held,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  hold_state_e state_q;

  // A flush or req in the same cycle turns a stall into a bubble, so the
  // stall counter only sees stalls that actually hold the register.
  logic stall_inc;
  logic bubble_inc;

  assign stall_inc  = stall & ~req & ~flush;
  assign bubble_inc = req | flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_pc      <= RESET_PC;
      out_payload <= '0;
      out_valid   <= 1'b0;
      out_bd      <= 1'b0;
      out_new     <= 1'b0;
      out_held    <= 1'b0;
      state_q     <= S_RUN;
    end else if (req) begin
      out_pc      <= EXC_VEC;
      out_payload <= '0;
      out_valid   <= 1'b0;
      out_bd      <= 1'b0;
      out_new     <= 1'b0;
      out_held    <= 1'b0;
      state_q     <= S_RUN;
    end else if (flush) begin
      // Bubble keeps the PC so EPC/debug still see where the slot was.
      out_pc      <= in_pc;
      out_payload <= '0;
      out_valid   <= 1'b0;
      out_bd      <= 1'b0;
      out_new     <= 1'b0;
      out_held    <= 1'b0;
      state_q     <= S_RUN;
    end else if (stall) begin
      out_new     <= 1'b0;
      out_held    <= 1'b1;
      state_q     <= S_HELD;
    end else begin
      out_pc      <= in_pc;
      out_payload <= in_payload;
      out_valid   <= in_valid;
      out_bd      <= in_bd;
      out_new     <= in_valid;
      out_held    <= 1'b0;
      state_q     <= S_RUN;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (stall_inc),
    .cnt   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (bubble_inc),
    .cnt   (bubble_cnt)
  );

  // state_q mirrors out_held; kept as the named FSM state for readability.
  logic unused_state;
  assign unused_state = (state_q == S_HELD);

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int          DATA_W  = 64;
  localparam int          CNT_W   = 2;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] EXC_PC  = 32'h00004180;
  localparam logic [31:0] RST_PC  = 32'h00000000;

  logic              clk = 1'b0;
  logic              reset = 1'b0, req = 1'b0, flush = 1'b0, stall = 1'b0, cnt_clr = 1'b0;
  logic [31:0]       in_pc = '0;
  logic [DATA_W-1:0] in_payload = '0;
  logic              in_valid = 1'b0, in_bd = 1'b0;
  logic [31:0]       out_pc;
  logic [DATA_W-1:0] out_payload;
  logic              out_valid, out_bd, out_new, out_held;
  logic [CNT_W-1:0]  stall_cnt, bubble_cnt;

  pipe_stage_reg #(
    .DATA_W   (DATA_W),
    .RESET_PC (RST_PC),
    .EXC_VEC  (EXC_PC),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .flush       (flush),
    .stall       (stall),
    .in_pc       (in_pc),
    .in_payload  (in_payload),
    .in_valid    (in_valid),
    .in_bd       (in_bd),
    .cnt_clr     (cnt_clr),
    .out_pc      (out_pc),
    .out_payload (out_payload),
    .out_valid   (out_valid),
    .out_bd      (out_bd),
    .out_new     (out_new),
    .out_held    (out_held),
    .stall_cnt   (stall_cnt),
    .bubble_cnt  (bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]       pc;
    logic [DATA_W-1:0] pl;
    logic              v;
    logic              bd;
    logic              nw;
    logic              held;
    int                sc;
    int                bc;
  } exp_t;

  exp_t q[$];
  exp_t m;          // reference view of what the register should present
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int sat_inc(int v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  // Behavioural rules: what the stage must show after an edge given the
  // controls presented before it.
  function automatic void model_step();
    bit s_inc, b_inc;
    s_inc = 0;
    b_inc = 0;
    if (reset) begin
      m.pc = RST_PC; m.pl = '0; m.v = 0; m.bd = 0; m.nw = 0; m.held = 0;
      m.sc = 0; m.bc = 0;
      return;
    end
    if (req) begin
      m.pc = EXC_PC; m.pl = '0; m.v = 0; m.bd = 0; m.nw = 0; m.held = 0;
      b_inc = 1;
    end else if (flush) begin
      m.pc = in_pc; m.pl = '0; m.v = 0; m.bd = 0; m.nw = 0; m.held = 0;
      b_inc = 1;
    end else if (stall) begin
      m.nw = 0; m.held = 1;
      s_inc = 1;
    end else begin
      m.pc = in_pc; m.pl = in_payload; m.v = in_valid; m.bd = in_bd;
      m.nw = in_valid; m.held = 0;
    end
    if (cnt_clr) begin
      m.sc = 0;
      m.bc = 0;
    end else begin
      if (s_inc) m.sc = sat_inc(m.sc);
      if (b_inc) m.bc = sat_inc(m.bc);
    end
  endfunction

  task automatic cycle();
    model_step();
    @(posedge clk);
    q.push_back(m);
    #1;
  endtask

  task automatic idle_ctl();
    reset = 0; req = 0; flush = 0; stall = 0; cnt_clr = 0;
  endtask

  // Monitor: the register presents a slot every cycle; compare at negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_pc",     64'(out_pc),      64'(e.pc));
        chk("sb_payload",64'(out_payload), 64'(e.pl));
        chk("sb_valid",  64'(out_valid),   64'(e.v));
        chk("sb_bd",     64'(out_bd),      64'(e.bd));
        chk("sb_new",    64'(out_new),     64'(e.nw));
        chk("sb_held",   64'(out_held),    64'(e.held));
        chk("sb_stall_cnt",  64'(stall_cnt),  64'(e.sc));
        chk("sb_bubble_cnt", 64'(bubble_cnt), 64'(e.bc));
      end
    end
  end

  initial begin
    m = '{pc: '0, pl: '0, v: 0, bd: 0, nw: 0, held: 0, sc: 0, bc: 0};

    // Reset with a live upstream slot
    reset = 1; in_pc = 32'h3000; in_valid = 1;
    cycle();
    chk("rst_pc",     64'(out_pc), 64'(RST_PC));
    chk("rst_valid",  64'(out_valid), 64'd0);
    chk("rst_held",   64'(out_held), 64'd0);
    chk("rst_scnt",   64'(stall_cnt), 64'd0);
    chk("rst_bcnt",   64'(bubble_cnt), 64'd0);

    // Load
    idle_ctl();
    in_pc = 32'h3004; in_payload = {(DATA_W/8){8'hA5}}; in_valid = 1; in_bd = 1;
    cycle();
    chk("load_pc",  64'(out_pc), 64'h3004);
    chk("load_new", 64'(out_new), 64'd1);
    chk("load_bd",  64'(out_bd), 64'd1);

    // Stall three cycles while upstream moves on
    stall = 1; in_pc = 32'h3008;
    cycle();
    chk("stall_new0", 64'(out_new), 64'd0);
    chk("stall_held", 64'(out_held), 64'd1);
    in_pc = 32'h300C;
    cycle();
    cycle();
    chk("stall_pc",   64'(out_pc), 64'h3004);
    chk("stall_cnt3", 64'(stall_cnt), 64'd3);
    stall = 0;
    cycle();
    chk("release_pc",   64'(out_pc), 64'h300C);
    chk("release_held", 64'(out_held), 64'd0);

    // Flush wins over stall
    flush = 1; stall = 1; in_pc = 32'h3010;
    cycle();
    chk("flush_pc",    64'(out_pc), 64'h3010);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_pl",    64'(out_payload), 64'd0);
    chk("flush_bcnt",  64'(bubble_cnt), 64'd1);
    chk("flush_scnt",  64'(stall_cnt), 64'd3);
    chk("flush_held",  64'(out_held), 64'd0);

    // Exception from HELD with everything asserted
    idle_ctl(); in_pc = 32'h3014;
    cycle();
    stall = 1;
    cycle();
    req = 1; flush = 1; stall = 1;
    cycle();
    chk("req_pc",    64'(out_pc), 64'(EXC_PC));
    chk("req_valid", 64'(out_valid), 64'd0);
    chk("req_bd",    64'(out_bd), 64'd0);
    chk("req_held",  64'(out_held), 64'd0);
    chk("req_bcnt",  64'(bubble_cnt), 64'd2);

    // Saturation and clear priority
    idle_ctl(); cnt_clr = 1;
    cycle();
    chk("clr_scnt", 64'(stall_cnt), 64'd0);
    cnt_clr = 0; stall = 1;
    repeat (5) cycle();
    chk("sat_scnt", 64'(stall_cnt), 64'd3);
    cnt_clr = 1;
    cycle();
    chk("clr_over_inc", 64'(stall_cnt), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      reset      = ($urandom_range(0, 99) < 2);
      req        = ($urandom_range(0, 99) < 4);
      flush      = ($urandom_range(0, 99) < 10);
      stall      = ($urandom_range(0, 99) < 30);
      cnt_clr    = ($urandom_range(0, 99) < 3);
      in_pc      = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      in_payload = {$urandom, $urandom};
      in_valid   = $urandom_range(0, 1);
      in_bd      = $urandom_range(0, 1);
      cycle();
    end
    idle_ctl();

    repeat (2) @(negedge clk);
    chk("sb_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
